firebird7_in_gate1_tessent_data_mux_ctrl: RTL and testbench

IJTAG-accessible controller that sequences the `ijtag_select` / `ijtag_data_in` side of the gate1 IJTAG data muxes. It is a scan test data register (capture/shift/update) plus a handover state machine. The state machine guarantees that mux data is stable for a programmable settle window before the mux switches to the IJTAG path, and again before it switches back to functional. It sits between the gate1 SIB/scan network and one `WIDTH`-bit data mux instance.

---
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl_pkg.sv | 19 +
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl_tdr.sv | 47 ++++
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv | 126 ++++++++++++
 tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_pkg.sv
// Shared types and constants for the gate1 IJTAG data-mux handover controller.
package firebird7_in_gate1_tessent_data_mux_ctrl_pkg;

  localparam int DEFAULT_WIDTH         = 3;
  localparam int DEFAULT_SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    FUNC    = 2'd0,
    ARM     = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } mux_state_e;

  // Settle counter must hold SETTLE_CYCLES-1; sized generously to stay >= 1 bit.
  function automatic int cnt_width(input int settle_cycles);
    return $clog2(settle_cycles + 1);
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_tdr.sv
// Capture/shift/update test data register: MSB is the select request, the rest is mux data.
module firebird7_in_gate1_tessent_data_mux_ctrl_tdr
  import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             i_sel,
  input  logic             i_ce,
  input  logic             i_se,
  input  logic             i_ue,
  input  logic             i_si,
  input  logic             i_capture_req,
  input  logic [WIDTH-1:0] i_capture_data,
  output logic             o_so,
  output logic             o_req_q,
  output logic [WIDTH-1:0] o_data_q
);

  logic [WIDTH:0] r_sr;
  logic [WIDTH:0] r_upd;

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_sr <= '0;
    end else if (i_sel && i_ce) begin
      r_sr <= {i_capture_req, i_capture_data};
    end else if (i_sel && i_se) begin
      r_sr <= {i_si, r_sr[WIDTH:1]};
    end
  end

  // Update samples the pre-edge shift value, so it composes with a same-cycle capture/shift.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_upd <= '0;
    end else if (i_sel && i_ue) begin
      r_upd <= r_sr;
    end
  end

  assign o_so     = r_sr[0];
  assign o_req_q  = r_upd[WIDTH];
  assign o_data_q = r_upd[WIDTH-1:0];

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Gate1 IJTAG data-mux controller: TDR plus a handover FSM that holds mux data stable
// for a settle window before switching to the IJTAG path and before switching back.
module firebird7_in_gate1_tessent_data_mux_ctrl
  import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             mux_busy
);

  localparam int CW = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  mux_state_e       r_state;
  mux_state_e       w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic             r_select;
  logic             r_busy;
  logic [WIDTH-1:0] r_data_out;
  logic             w_req_q;
  logic [WIDTH-1:0] w_data_q;
  logic             w_state_active;

  assign w_state_active = (r_state == ACTIVE);

  firebird7_in_gate1_tessent_data_mux_ctrl_tdr #(
    .WIDTH (WIDTH)
  ) u_tdr (
    .ijtag_tck      (ijtag_tck),
    .ijtag_reset    (ijtag_reset),
    .i_sel          (ijtag_sel),
    .i_ce           (ijtag_ce),
    .i_se           (ijtag_se),
    .i_ue           (ijtag_ue),
    .i_si           (ijtag_si),
    .i_capture_req  (w_state_active),
    .i_capture_data (functional_data_in),
    .o_so           (ijtag_so),
    .o_req_q        (w_req_q),
    .o_data_q       (w_data_q)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      FUNC: begin
        if (w_req_q) begin
          w_state_next = ARM;
          w_cnt_next   = CNT_LOAD;
        end
      end
      ARM: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CW'(1);
        end else begin
          w_state_next = w_req_q ? ACTIVE : FUNC;
        end
      end
      ACTIVE: begin
        if (!w_req_q) begin
          w_state_next = RELEASE;
          w_cnt_next   = CNT_LOAD;
        end
      end
      RELEASE: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CW'(1);
        end else if (w_req_q) begin
          // A re-request during release is honoured only after the full settle window.
          w_state_next = ARM;
          w_cnt_next   = CNT_LOAD;
        end else begin
          w_state_next = FUNC;
        end
      end
      default: begin
        w_state_next = FUNC;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_state <= FUNC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Outputs follow next_state so they line up with the state register on the same edge.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_select   <= 1'b0;
      r_busy     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_select <= (w_state_next == ACTIVE);
      r_busy   <= (w_state_next == ARM) || (w_state_next == RELEASE);
      if (w_req_q && (r_state != RELEASE)) begin
        r_data_out <= w_data_q;
      end
    end
  end

  assign ijtag_select   = r_select;
  assign mux_busy       = r_busy;
  assign ijtag_data_out = r_data_out;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Directed self-checking bench for the gate1 data-mux controller (SETTLE=2, plus a SETTLE=1 copy).
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

  logic       tck = 1'b0;
  logic       rst;
  logic       sel, ce, se, ue, si;
  logic [2:0] fdi;
  logic       so, sel_out, busy;
  logic [2:0] dout;
  logic       so_s1, sel_out_s1, busy_s1;
  logic [2:0] dout_s1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 tck = ~tck;

  firebird7_in_gate1_tessent_data_mux_ctrl #(.WIDTH(3), .SETTLE_CYCLES(2)) u_dut (
    .ijtag_tck          (tck),
    .ijtag_reset        (rst),
    .ijtag_sel          (sel),
    .ijtag_ce           (ce),
    .ijtag_se           (se),
    .ijtag_ue           (ue),
    .ijtag_si           (si),
    .ijtag_so           (so),
    .functional_data_in (fdi),
    .ijtag_select       (sel_out),
    .ijtag_data_out     (dout),
    .mux_busy           (busy)
  );

  firebird7_in_gate1_tessent_data_mux_ctrl #(.WIDTH(3), .SETTLE_CYCLES(1)) u_dut_s1 (
    .ijtag_tck          (tck),
    .ijtag_reset        (rst),
    .ijtag_sel          (sel),
    .ijtag_ce           (ce),
    .ijtag_se           (se),
    .ijtag_ue           (ue),
    .ijtag_si           (si),
    .ijtag_so           (so_s1),
    .functional_data_in (fdi),
    .ijtag_select       (sel_out_s1),
    .ijtag_data_out     (dout_s1),
    .mux_busy           (busy_s1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input logic s, input logic c, input logic sh, input logic u, input logic d);
    sel = s; ce = c; se = sh; ue = u; si = d;
    @(posedge tck);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Four shifts place data[0] at sr[0] and req at sr[3].
  task automatic shift_in(input logic req, input logic [2:0] data);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, (i < 3) ? data[i] : req);
    end
  endtask

  task automatic update();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sel = 0; ce = 0; se = 0; ue = 0; si = 0; fdi = 3'b000;
    #12;
    check("rst_select", int'(sel_out), 0);
    check("rst_data",   int'(dout), 0);
    check("rst_busy",   int'(busy), 0);
    check("rst_so",     int'(so), 0);
    @(posedge tck); #1;
    rst = 1'b0;
    repeat (5) idle();
    check("idle_select", int'(sel_out), 0);
    check("idle_data",   int'(dout), 0);
    check("idle_busy",   int'(busy), 0);

    // capture then shift: so walks fdi[0..2] then the (zero) request bit
    fdi = 3'b101;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); check("cap_so0", int'(so), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); check("sh_so1",  int'(so), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); check("sh_so2",  int'(so), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); check("sh_so3",  int'(so), 0);

    // engage {1,101}
    shift_in(1'b1, 3'b101);
    update();
    check("eng_k_busy", int'(busy), 0);
    idle();
    check("eng_k1_data",   int'(dout), 5);
    check("eng_k1_busy",   int'(busy), 1);
    check("eng_k1_select", int'(sel_out), 0);
    check("s1_k1_busy",    int'(busy_s1), 1);
    check("s1_k1_select",  int'(sel_out_s1), 0);
    check("s1_k1_data",    int'(dout_s1), 5);
    idle();
    check("eng_k2_select", int'(sel_out), 0);
    check("eng_k2_busy",   int'(busy), 1);
    check("s1_k2_select",  int'(sel_out_s1), 1);
    check("s1_k2_busy",    int'(busy_s1), 0);
    idle();
    check("eng_k3_select", int'(sel_out), 1);
    check("eng_k3_busy",   int'(busy), 0);

    // data-only update in ACTIVE
    shift_in(1'b1, 3'b010);
    check("act_shift_select", int'(sel_out), 1);
    update();
    idle();
    check("act_data",   int'(dout), 2);
    check("act_select", int'(sel_out), 1);
    check("act_busy",   int'(busy), 0);

    // release {0,111}: data must not change
    shift_in(1'b0, 3'b111);
    update();
    idle();
    check("rel_k1_select", int'(sel_out), 0);
    check("rel_k1_busy",   int'(busy), 1);
    check("rel_k1_data",   int'(dout), 2);
    idle();
    check("rel_k2_busy",   int'(busy), 1);
    idle();
    check("rel_k3_busy",   int'(busy), 0);
    check("rel_k3_select", int'(sel_out), 0);
    check("rel_k3_data",   int'(dout), 2);

    // abort during ARM: update {1,001} with same-cycle capture {0,100}, then update that
    shift_in(1'b1, 3'b001);
    fdi = 3'b100;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    update();
    check("abt_k1_busy",   int'(busy), 1);
    check("abt_k1_select", int'(sel_out), 0);
    check("abt_k1_data",   int'(dout), 1);
    idle();
    check("abt_k2_busy",   int'(busy), 1);
    check("abt_k2_select", int'(sel_out), 0);
    check("abt_k2_data",   int'(dout), 1);
    idle();
    check("abt_k3_busy",   int'(busy), 0);
    check("abt_k3_select", int'(sel_out), 0);
    idle();
    check("abt_k4_select", int'(sel_out), 0);
    check("abt_k4_busy",   int'(busy), 0);

    // engage {1,011}, then release with a re-request landing in RELEASE
    shift_in(1'b1, 3'b011);
    update();
    repeat (3) idle();
    check("re_act_select", int'(sel_out), 1);
    check("re_act_data",   int'(dout), 3);
    shift_in(1'b0, 3'b111);
    fdi = 3'b110;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    update();
    check("re_k1_select", int'(sel_out), 0);
    check("re_k1_busy",   int'(busy), 1);
    check("re_k1_data",   int'(dout), 3);
    idle();
    check("re_k2_data",   int'(dout), 3);
    check("re_k2_busy",   int'(busy), 1);
    idle();
    check("re_k3_busy",   int'(busy), 1);
    check("re_k3_select", int'(sel_out), 0);
    check("re_k3_data",   int'(dout), 3);
    idle();
    check("re_k4_data",   int'(dout), 6);
    check("re_k4_select", int'(sel_out), 0);
    idle();
    check("re_k5_select", int'(sel_out), 1);
    check("re_k5_busy",   int'(busy), 0);
    check("re_k5_data",   int'(dout), 6);

    // asynchronous reset while ACTIVE, mid-cycle
    #1 rst = 1'b1;
    #1;
    check("arst_select", int'(sel_out), 0);
    check("arst_data",   int'(dout), 0);
    check("arst_busy",   int'(busy), 0);
    #1 rst = 1'b0;
    repeat (3) idle();
    check("post_rst_select", int'(sel_out), 0);
    check("post_rst_busy",   int'(busy), 0);
    check("post_rst_data",   int'(dout), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
